// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: access-type encodings, FSM states,
// the latched request layout and an access-size helper.
package dm_arb_pkg;

  localparam logic [2:0] CtrlB  = 3'b000;
  localparam logic [2:0] CtrlH  = 3'b001;
  localparam logic [2:0] CtrlW  = 3'b010;
  localparam logic [2:0] CtrlBu = 3'b100;
  localparam logic [2:0] CtrlHu = 3'b101;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  typedef struct packed {
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  // Illegal encodings report 4 bytes; they are rejected separately anyway.
  function automatic logic [2:0] access_size(input logic [2:0] ctrl);
    logic [2:0] size;
    case (ctrl)
      CtrlB, CtrlBu: size = 3'd1;
      CtrlH, CtrlHu: size = 3'd2;
      default:       size = 3'd4;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way request picker: fixed priority (port 0) or round-robin against the last grant.
module dm_arb_rr (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       mode_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    // On a tie, round-robin favours whichever port was not granted last.
    if (valid_i == 2'b11) begin
      grant_o = (mode_i && !last_grant_i) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (IDLE -> ISSUE -> RESP).
// Optional performance counters are enabled with `define DM_ARBITER_PERF_CNT_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned ARB_MODE  = 1
`ifdef DM_ARBITER_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [2:0]        p0_ctrl,
  input  logic [31:0]       p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [2:0]        p1_ctrl,
  input  logic [31:0]       p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rsp_rdata,
  output logic              p1_rsp_err,
`ifdef DM_ARBITER_PERF_CNT_EN
  output logic [CNT_W-1:0]  p0_grants,
  output logic [CNT_W-1:0]  p1_grants,
  output logic [CNT_W-1:0]  conflicts,
`endif
  output logic              dm_wr,
  output logic [2:0]        dm_ctrl,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  dm_req_t     req_q, req_d;
  logic        err_q, err_d;
  logic        port_q, port_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  dm_req_t     req0, req1, req_sel;
  logic [1:0]  grant, ready;
  logic        arb_mode;

  function automatic logic req_error(input dm_req_t r);
    logic [32:0] end_addr;
    logic        bad;
    end_addr = {1'b0, r.addr} + {30'd0, access_size(r.ctrl)};
    bad      = end_addr > 33'(MEM_BYTES);
    case (r.ctrl)
      CtrlB:   bad = bad;
      CtrlBu:  bad = bad | r.we;
      CtrlH:   bad = bad | r.addr[0];
      CtrlHu:  bad = bad | r.addr[0] | r.we;
      CtrlW:   bad = bad | (|r.addr[1:0]);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign arb_mode = (ARB_MODE != 0);
  assign req0     = '{we: p0_we, ctrl: p0_ctrl, addr: p0_addr, wdata: p0_wdata};
  assign req1     = '{we: p1_we, ctrl: p1_ctrl, addr: p1_addr, wdata: p1_wdata};

  dm_arb_rr u_rr (
    .valid_i      ({p1_valid, p0_valid}),
    .last_grant_i (last_grant_q),
    .mode_i       (arb_mode),
    .grant_o      (grant)
  );

  assign ready    = (state_q == StIdle) ? grant : 2'b00;
  assign p0_ready = ready[0];
  assign p1_ready = ready[1];
  assign req_sel  = ready[1] ? req1 : req0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    err_d        = err_q;
    port_d       = port_q;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (|ready) begin
          state_d      = StIssue;
          last_grant_d = ready[1];
          port_d       = ready[1];
          req_d        = req_sel;
          err_d        = req_error(req_sel);
          rsp_rdata_d  = '0;
        end
      end
      StIssue: begin
        state_d     = StResp;
        rsp_rdata_d = (!req_q.we && !err_q) ? dm_rdata : 32'd0;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      req_q        <= '0;
      err_q        <= 1'b0;
      port_q       <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      err_q        <= err_d;
      port_q       <= port_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // Memory bus is only live in ISSUE; a rejected request keeps the address bus at zero.
  always_comb begin
    dm_wr    = 1'b0;
    dm_ctrl  = 3'b000;
    dm_addr  = 32'd0;
    dm_wdata = 32'd0;
    if (state_q == StIssue) begin
      dm_wr    = req_q.we & ~err_q;
      dm_ctrl  = req_q.ctrl;
      dm_addr  = err_q ? 32'd0 : req_q.addr;
      dm_wdata = req_q.wdata;
    end
  end

  assign p0_rsp_valid = (state_q == StResp) && !port_q;
  assign p1_rsp_valid = (state_q == StResp) && port_q;
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_rdata_q : 32'd0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_rdata_q : 32'd0;
  assign p0_rsp_err   = p0_rsp_valid & err_q;
  assign p1_rsp_err   = p1_rsp_valid & err_q;

`ifdef DM_ARBITER_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] p0_grants_q, p0_grants_d;
  logic [CNT_W-1:0] p1_grants_q, p1_grants_d;
  logic [CNT_W-1:0] conflicts_q, conflicts_d;

  always_comb begin
    p0_grants_d = p0_grants_q;
    p1_grants_d = p1_grants_q;
    conflicts_d = conflicts_q;
    if (ready[0] && p0_grants_q != CntMax) p0_grants_d = p0_grants_q + 1'b1;
    if (ready[1] && p1_grants_q != CntMax) p1_grants_d = p1_grants_q + 1'b1;
    if (state_q == StIdle && p0_valid && p1_valid && conflicts_q != CntMax) begin
      conflicts_d = conflicts_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_grants_q <= '0;
      p1_grants_q <= '0;
      conflicts_q <= '0;
    end else begin
      p0_grants_q <= p0_grants_d;
      p1_grants_q <= p1_grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign p0_grants = p0_grants_q;
  assign p1_grants = p1_grants_q;
  assign conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: byte-array memory, transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_dm_arbiter;

  localparam int MemBytes = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
  logic [2:0]  p0_ctrl;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
  logic [2:0]  p1_ctrl;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic        dm_wr;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  // Second instance in fixed-priority mode, used only for the starvation scenario.
  logic        f_p0_valid, f_p0_ready, f_p0_rsp_valid, f_p0_rsp_err;
  logic        f_p1_valid, f_p1_ready, f_p1_rsp_valid, f_p1_rsp_err;
  logic [31:0] f_p0_rsp_rdata, f_p1_rsp_rdata, f_dm_addr, f_dm_wdata;
  logic        f_dm_wr;
  logic [2:0]  f_dm_ctrl;

`ifdef DM_ARBITER_PERF_CNT_EN
  logic [3:0] p0_grants, p1_grants, conflicts;
  logic [3:0] f_p0_grants, f_p1_grants, f_conflicts;
`endif

  dm_arbiter #(
    .MEM_BYTES (MemBytes),
    .ARB_MODE  (1)
`ifdef DM_ARBITER_PERF_CNT_EN
    ,
    .CNT_W     (4)
`endif
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_valid     (p0_valid),
    .p0_ready     (p0_ready),
    .p0_we        (p0_we),
    .p0_ctrl      (p0_ctrl),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p0_rsp_err   (p0_rsp_err),
    .p1_valid     (p1_valid),
    .p1_ready     (p1_ready),
    .p1_we        (p1_we),
    .p1_ctrl      (p1_ctrl),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_rdata (p1_rsp_rdata),
    .p1_rsp_err   (p1_rsp_err),
`ifdef DM_ARBITER_PERF_CNT_EN
    .p0_grants    (p0_grants),
    .p1_grants    (p1_grants),
    .conflicts    (conflicts),
`endif
    .dm_wr        (dm_wr),
    .dm_ctrl      (dm_ctrl),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata)
  );

  dm_arbiter #(
    .MEM_BYTES (MemBytes),
    .ARB_MODE  (0)
`ifdef DM_ARBITER_PERF_CNT_EN
    ,
    .CNT_W     (4)
`endif
  ) u_fixed (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_valid     (f_p0_valid),
    .p0_ready     (f_p0_ready),
    .p0_we        (1'b0),
    .p0_ctrl      (3'b010),
    .p0_addr      (32'd0),
    .p0_wdata     (32'd0),
    .p0_rsp_valid (f_p0_rsp_valid),
    .p0_rsp_rdata (f_p0_rsp_rdata),
    .p0_rsp_err   (f_p0_rsp_err),
    .p1_valid     (f_p1_valid),
    .p1_ready     (f_p1_ready),
    .p1_we        (1'b0),
    .p1_ctrl      (3'b010),
    .p1_addr      (32'd4),
    .p1_wdata     (32'd0),
    .p1_rsp_valid (f_p1_rsp_valid),
    .p1_rsp_rdata (f_p1_rsp_rdata),
    .p1_rsp_err   (f_p1_rsp_err),
`ifdef DM_ARBITER_PERF_CNT_EN
    .p0_grants    (f_p0_grants),
    .p1_grants    (f_p1_grants),
    .conflicts    (f_conflicts),
`endif
    .dm_wr        (f_dm_wr),
    .dm_ctrl      (f_dm_ctrl),
    .dm_addr      (f_dm_addr),
    .dm_wdata     (f_dm_wdata),
    .dm_rdata     (32'd0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // ---------------- memory environment (the real memory the DUT drives) ----------------
  logic [7:0]  mem [MemBytes];
  bit          mem_init_done = 1'b0;
  logic [12:0] a0, a1, a2, a3;
  logic [31:0] raw;
  assign a0 = dm_addr[12:0];
  assign a1 = a0 + 13'd1;
  assign a2 = a0 + 13'd2;
  assign a3 = a0 + 13'd3;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MemBytes; i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (dm_wr) begin
      mem[a0] <= dm_wdata[7:0];
      if (dm_ctrl[1:0] != 2'b00) mem[a1] <= dm_wdata[15:8];
      if (dm_ctrl[1:0] == 2'b10) begin
        mem[a2] <= dm_wdata[23:16];
        mem[a3] <= dm_wdata[31:24];
      end
    end
  end

  always_comb begin
    raw = {mem[a3], mem[a2], mem[a1], mem[a0]};
    case (dm_ctrl)
      3'b000:  dm_rdata = {{24{raw[7]}}, raw[7:0]};
      3'b100:  dm_rdata = {24'd0, raw[7:0]};
      3'b001:  dm_rdata = {{16{raw[15]}}, raw[15:0]};
      3'b101:  dm_rdata = {16'd0, raw[15:0]};
      default: dm_rdata = raw;
    endcase
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [MemBytes];
  int cyc = 0;
  int free_c = 0, issue_c = -1, resp_c = -1;
  int last_m = 1;
  int t_port = 0;
  logic t_we, t_err;
  logic [2:0] t_ctrl;
  logic [31:0] t_addr, t_wdata, t_rdata;
  int cnt_g0 = 0, cnt_g1 = 0, cnt_conf = 0;
  logic hs0 = 1'b0, hs1 = 1'b0;

  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic ref_err(input logic we, input logic [2:0] c, input logic [31:0] a);
    int sz;
    sz = size_of(c);
    if (sz == 0) return 1'b1;
    if (longint'({32'd0, a}) + longint'(sz) > longint'(MemBytes)) return 1'b1;
    if (sz == 2 && a[0]) return 1'b1;
    if (sz == 4 && a[1:0] != 2'b00) return 1'b1;
    if (we && c[2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a);
    int base;
    logic [31:0] v;
    base = int'(a);
    v = {ref_mem[(base + 3) % MemBytes], ref_mem[(base + 2) % MemBytes],
         ref_mem[(base + 1) % MemBytes], ref_mem[base % MemBytes]};
    case (c)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic int sat15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic model_step();
    logic [1:0]  v, e_ready, e_rv;
    logic        e_wr, e_re;
    logic [2:0]  e_ctrl;
    logic [31:0] e_addr, e_wdata, e_rd;
    int w, sz;
    v = {p1_valid, p0_valid};
    e_ready = 2'b00; e_rv = 2'b00; e_wr = 1'b0; e_re = 1'b0;
    e_ctrl = 3'b000; e_addr = 32'd0; e_wdata = 32'd0; e_rd = 32'd0;
    if (!rst_n) begin
      free_c = 0; issue_c = -1; resp_c = -1; last_m = 1;
      cnt_g0 = 0; cnt_g1 = 0; cnt_conf = 0;
    end else begin
      if (cyc >= free_c) begin
        w = -1;
        if (v == 2'b11) begin
          w = (last_m == 0) ? 1 : 0;
          cnt_conf++;
        end else if (v[0]) w = 0;
        else if (v[1]) w = 1;
        if (w >= 0) begin
          e_ready[w] = 1'b1;
          last_m = w;
          t_port = w;
          if (w == 0) begin
            cnt_g0++;
            t_we = p0_we; t_ctrl = p0_ctrl; t_addr = p0_addr; t_wdata = p0_wdata;
          end else begin
            cnt_g1++;
            t_we = p1_we; t_ctrl = p1_ctrl; t_addr = p1_addr; t_wdata = p1_wdata;
          end
          t_err = ref_err(t_we, t_ctrl, t_addr);
          t_rdata = (!t_we && !t_err) ? ref_load(t_ctrl, t_addr) : 32'd0;
          issue_c = cyc + 1; resp_c = cyc + 2; free_c = cyc + 3;
        end
      end
      if (cyc == issue_c) begin
        e_wr = t_we & ~t_err;
        e_ctrl = t_ctrl;
        e_addr = t_err ? 32'd0 : t_addr;
        e_wdata = t_wdata;
        if (e_wr) begin
          sz = size_of(t_ctrl);
          for (int k = 0; k < sz; k++) ref_mem[int'(t_addr) + k] = t_wdata[8*k +: 8];
        end
      end
      if (cyc == resp_c) begin
        e_rv[t_port] = 1'b1;
        e_rd = t_rdata;
        e_re = t_err;
      end
    end
    hs0 = p0_valid & p0_ready;
    hs1 = p1_valid & p1_ready;
    check("p0_ready", 32'(p0_ready), 32'(e_ready[0]));
    check("p1_ready", 32'(p1_ready), 32'(e_ready[1]));
    check("dm_wr", 32'(dm_wr), 32'(e_wr));
    check("dm_ctrl", 32'(dm_ctrl), 32'(e_ctrl));
    check("dm_addr", dm_addr, e_addr);
    check("dm_wdata", dm_wdata, e_wdata);
    check("p0_rsp_valid", 32'(p0_rsp_valid), 32'(e_rv[0]));
    check("p1_rsp_valid", 32'(p1_rsp_valid), 32'(e_rv[1]));
    check("p0_rsp_rdata", p0_rsp_rdata, e_rv[0] ? e_rd : 32'd0);
    check("p1_rsp_rdata", p1_rsp_rdata, e_rv[1] ? e_rd : 32'd0);
    check("p0_rsp_err", 32'(p0_rsp_err), 32'(e_rv[0] & e_re));
    check("p1_rsp_err", 32'(p1_rsp_err), 32'(e_rv[1] & e_re));
`ifdef DM_ARBITER_PERF_CNT_EN
    check("p0_grants", 32'(p0_grants), 32'(sat15(cnt_g0)));
    check("p1_grants", 32'(p1_grants), 32'(sat15(cnt_g1)));
    check("conflicts", 32'(conflicts), 32'(sat15(cnt_conf)));
`endif
  endtask

  initial begin : compare_proc
    for (int i = 0; i < MemBytes; i++) ref_mem[i] = pat(i);
    forever begin
      @(negedge clk);
      cyc++;
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int p, input logic v, input logic we, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_valid = v; p0_we = we; p0_ctrl = c; p0_addr = a; p0_wdata = d;
    end else begin
      p1_valid = v; p1_we = we; p1_ctrl = c; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic wait_hs(input int p);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? (p0_valid & p0_ready) : (p1_valid & p1_ready);
    end
    check("handshake_seen", 32'(ok), 32'd1);
  endtask

  task automatic txn(input int p, input logic we, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er);
    drive(p, 1'b1, we, c, a, d);
    wait_hs(p);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rd = (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
    er = (p == 0) ? p0_rsp_err : p1_rsp_err;
    check("txn_rsp_valid", 32'((p == 0) ? p0_rsp_valid : p1_rsp_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [2:0] legal_c [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [2:0] bad_c [3]   = '{3'b011, 3'b110, 3'b111};

  task automatic rand_port(input int p);
    logic [31:0] a;
    logic [2:0]  c;
    int r;
    r = $urandom_range(0, 99);
    c = (r < 88) ? legal_c[$urandom_range(0, 4)] : bad_c[$urandom_range(0, 2)];
    r = $urandom_range(0, 99);
    if (r < 70) a = 32'($urandom_range(0, 63));
    else if (r < 92) a = 32'($urandom_range(8184, 8191));
    else a = $urandom;
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    drive(p, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)), c, a, $urandom);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] rd;
    logic er;
    int seq [8];
    int n, f0, f1, fr0, fr1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    f_p0_valid = 1'b0;
    f_p1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dm_wr", 32'(dm_wr), 32'd0);
    check("reset_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store word then read it back from the other port.
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    check("t1_store_err", 32'(er), 32'd0);
    check("t1_store_rdata", rd, 32'd0);
    txn(1, 1'b0, 3'b010, 32'h10, 32'd0, rd, er);
    check("t1_load_w", rd, 32'hDEADBEEF);
    check("t1_load_err", 32'(er), 32'd0);

    // Byte sign/zero extension.
    txn(0, 1'b1, 3'b000, 32'h21, 32'h00000080, rd, er);
    txn(1, 1'b0, 3'b000, 32'h21, 32'd0, rd, er);
    check("t2_load_b", rd, 32'hFFFFFF80);
    txn(0, 1'b0, 3'b100, 32'h21, 32'd0, rd, er);
    check("t2_load_bu", rd, 32'h00000080);

    // Rejected requests leave memory alone.
    txn(0, 1'b1, 3'b001, 32'h3, 32'h0000AAAA, rd, er);
    check("t4_st_h_misalign_err", 32'(er), 32'd1);
    txn(1, 1'b0, 3'b010, 32'h1FFE, 32'd0, rd, er);
    check("t4_ld_w_range_err", 32'(er), 32'd1);
    check("t4_ld_w_range_rdata", rd, 32'd0);
    txn(0, 1'b1, 3'b100, 32'h30, 32'h00000055, rd, er);
    check("t4_st_bu_err", 32'(er), 32'd1);
    txn(1, 1'b0, 3'b100, 32'h3, 32'd0, rd, er);
    check("t4_mem_0x3", rd, 32'h0000007A);
    txn(1, 1'b0, 3'b100, 32'h30, 32'd0, rd, er);
    check("t4_mem_0x30", rd, 32'h000000FB);
    txn(0, 1'b0, 3'b101, 32'h1FFE, 32'd0, rd, er);
    check("t4_top_hu", rd, 32'h0000E6C1);
    check("t4_top_hu_err", 32'(er), 32'd0);

    // Reset while a store is in ISSUE.
    drive(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h12345678);
    wait_hs(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    check("t5_dm_wr_in_issue", 32'(dm_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_dm_wr_async_drop", 32'(dm_wr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous contention alternates, starting with port 0 after reset.
    drive(0, 1'b1, 1'b0, 3'b010, 32'h0, 32'd0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'd0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (p0_ready && n < 8) begin seq[n] = 0; n++; end
      if (p1_ready && n < 8) begin seq[n] = 1; n++; end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    check("t3_rr_grants", 32'(n), 32'd4);
    for (int i = 0; i < 4 && i < n; i++) check("t3_rr_order", 32'(seq[i]), 32'(i % 2));
    @(posedge clk); #1;
    txn(0, 1'b0, 3'b010, 32'h40, 32'd0, rd, er);
    check("t5_store_discarded", rd, 32'hBA95704B);

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      if (!p0_valid || hs0) rand_port(0);
      else if ($urandom_range(0, 99) < 8) p0_valid = 1'b0;
      if (!p1_valid || hs1) rand_port(1);
      else if ($urandom_range(0, 99) < 8) p1_valid = 1'b0;
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (4) @(posedge clk);
    #1;
`ifdef DM_ARBITER_PERF_CNT_EN
    check("perf_p0_sat", 32'(p0_grants), 32'd15);
    check("perf_p1_sat", 32'(p1_grants), 32'd15);
    check("perf_conf_sat", 32'(conflicts), 32'd15);
`endif

    // Fixed priority: port 1 starves.
    f_p0_valid = 1'b1;
    f_p1_valid = 1'b1;
    f0 = 0; f1 = 0; fr0 = 0; fr1 = 0;
    repeat (30) begin
      @(negedge clk);
      if (f_p0_ready) f0++;
      if (f_p1_ready) f1++;
      if (f_p0_rsp_valid) fr0++;
      if (f_p1_rsp_valid) fr1++;
    end
    @(posedge clk); #1;
    f_p0_valid = 1'b0;
    f_p1_valid = 1'b0;
    check("fixed_p0_grants", 32'(f0), 32'd10);
    check("fixed_p1_grants", 32'(f1), 32'd0);
    check("fixed_p0_rsps", 32'(fr0), 32'd10);
    check("fixed_p1_rsps", 32'(fr1), 32'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
